// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit for the Execute stage. A start in IDLE
//   latches conditioned (magnitude) operands, then runs 32 shift-add (MUL) or
//   32 restoring shift-subtract (DIV) steps, and presents the sign-corrected
//   result for one cycle in DONE. Divide-by-zero and signed overflow skip the
//   iterations and go straight to DONE.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   FlushE     : Execute flush, aborts any operation (beats StartE)
//   StartE     : mul/div instruction present in Execute
//   MDOpE      : 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   SrcAE      : rs1 operand
//   SrcBE      : rs2 operand
//   StallMD    : holds Fetch/Decode/Execute while high
//   MDValidE   : MDResultE valid this cycle (DONE only)
//   MDResultE  : result, zero outside DONE
module muldiv_sequencer #(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  FlushE,
  input  logic                  StartE,
  input  logic [2:0]            MDOpE,
  input  logic [word_width-1:0] SrcAE,
  input  logic [word_width-1:0] SrcBE,
  output logic                  StallMD,
  output logic                  MDValidE,
  output logic [word_width-1:0] MDResultE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;      // multiplicand magnitude
  logic [31:0] b_q;      // divisor magnitude
  logic [63:0] prod;     // upper half accumulates, lower half shifts out the multiplier
  logic [31:0] quot;     // dividend shifts out the top as quotient bits shift in
  logic [32:0] rem;      // partial remainder
  logic        neg_q;    // negate product / quotient in DONE
  logic        neg_r;    // negate remainder in DONE (dividend sign)

  // ---------------------------------------------------------------------------
  // Operand conditioning at start
  // ---------------------------------------------------------------------------
  logic        a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf, start;
  logic [31:0] a_mag, b_mag;

  // MUL's low word is sign-independent, so it is treated as unsigned.
  assign a_signed = (MDOpE == OP_MULH) || (MDOpE == OP_MULHSU) ||
                    (MDOpE == OP_DIV)  || (MDOpE == OP_REM);
  assign b_signed = (MDOpE == OP_MULH) || (MDOpE == OP_DIV) || (MDOpE == OP_REM);
  assign a_neg    = a_signed && SrcAE[31];
  assign b_neg    = b_signed && SrcBE[31];
  assign a_mag    = a_neg ? (32'd0 - SrcAE) : SrcAE;
  assign b_mag    = b_neg ? (32'd0 - SrcBE) : SrcBE;
  assign is_div   = MDOpE[2];
  assign div_zero = is_div && (SrcBE == 32'd0);
  assign div_ovf  = is_div && !MDOpE[0] &&
                    (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
  assign start    = (state == IDLE) && StartE && !FlushE;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] prod_next;
  logic [33:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;

  assign mul_sum   = {1'b0, prod[63:32]} + {1'b0, a_q};
  assign prod_next = prod[0] ? {mul_sum, prod[31:1]} : {1'b0, prod[63:1]};

  // The partial remainder stays below the divisor, so the shifted value fits
  // in 33 bits and the 33-bit difference is exact whenever div_ge holds.
  assign div_shift = {rem, quot[31]};
  assign div_ge    = div_shift >= {2'b00, b_q};
  assign div_diff  = div_shift[32:0] - {1'b0, b_q};

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the datapath registers are reset too so outputs and
  // internal state are fully defined straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      prod  <= '0;
      quot  <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (FlushE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= MDOpE;
            cnt  <= '0;
            a_q  <= a_mag;
            b_q  <= b_mag;
            if (!is_div) begin
              prod  <= {32'd0, b_mag};
              neg_q <= a_neg ^ b_neg;
              neg_r <= 1'b0;
              state <= MUL;
            end else if (div_zero) begin
              quot  <= 32'hFFFF_FFFF;
              rem   <= {1'b0, SrcAE};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else if (div_ovf) begin
              quot  <= 32'h8000_0000;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else begin
              quot  <= a_mag;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= DIV;
            end
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end
        DIV: begin
          quot <= {quot[30:0], div_ge};
          rem  <= div_ge ? div_diff : div_shift[32:0];
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= DONE;
        end
        default: state <= IDLE;   // DONE ignores StartE: it belongs to the completing op
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s;

  assign prod_s = neg_q ? (64'd0 - prod) : prod;
  assign quot_s = neg_q ? (32'd0 - quot) : quot;
  assign rem_s  = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];

  assign StallMD  = start || (state == MUL) || (state == DIV);
  assign MDValidE = (state == DONE);

  // NOTE: defaulting the output first keeps this block free of inferred latches.
  always_comb begin
    MDResultE = '0;
    if (state == DONE) begin
      case (op_q)
        OP_MUL:             MDResultE = prod_s[31:0];
        3'd1, 3'd2, 3'd3:   MDResultE = prod_s[63:32];
        3'd4, 3'd5:         MDResultE = quot_s;
        default:            MDResultE = rem_s;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed-vector bench for muldiv_sequencer: each vector carries a
//   hand-computed result and its MDValidE cycle (start cycle = 1). Operands
//   are scrambled after the start cycle, StartE is held high while stalled and
//   in DONE, and flush and mid-operation reset are exercised.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FlushE, StartE;
  logic [2:0]  MDOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        StallMD, MDValidE;
  logic [31:0] MDResultE;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.word_width(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .FlushE    (FlushE),
    .StartE    (StartE),
    .MDOpE     (MDOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .StallMD   (StallMD),
    .MDValidE  (MDValidE),
    .MDResultE (MDResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start an operation, run it to MDValidE (bounded), check latency,
  // stall count, result, and the return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    int stalls;
    @(negedge clk);
    StartE = 1'b1; MDOpE = op; SrcAE = a; SrcBE = b;
    #1;
    cyc = 1; stalls = 0;
    while (!MDValidE && cyc < 100) begin
      if (StallMD) stalls++;
      if (cyc == 2) check({tag, " busy result"}, MDResultE, 32'd0);
      @(posedge clk); #1;
      SrcAE = ~a; SrcBE = b ^ 32'h0000_5a5a; MDOpE = op ^ 3'd1;
      @(negedge clk); #1;
      cyc++;
    end
    check({tag, " valid"},  {31'd0, MDValidE}, 32'd1);
    check({tag, " cycle"},  32'(cyc), 32'(exp_cyc));
    check({tag, " result"}, MDResultE, exp_res);
    check({tag, " stall in done"}, {31'd0, StallMD}, 32'd0);
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_cyc - 1));
    @(posedge clk); #1;
    StartE = 1'b0;
    @(negedge clk);
    check({tag, " idle valid"},  {31'd0, MDValidE}, 32'd0);
    check({tag, " idle result"}, MDResultE, 32'd0);
  endtask

  initial begin
    int valids;
    rst_n = 1'b0; FlushE = 1'b0; StartE = 1'b0;
    MDOpE = '0; SrcAE = '0; SrcBE = '0;
    #3;
    check("reset stall",  {31'd0, StallMD},  32'd0);
    check("reset valid",  {31'd0, MDValidE}, 32'd0);
    check("reset result", MDResultE, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Normal operations: 33 stall cycles, valid in cycle 34
    run_op("mul 7*-3",      3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh -1*-1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("div -20/3",     3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
    run_op("rem -20/3",     3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
    run_op("divu 100/7",    3'd5, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu 100/7",    3'd7, 32'd100, 32'd7, 32'd2, 34);

    // Special cases: valid in cycle 2
    run_op("div 5/0",       3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem 5/0",       3'd6, 32'd5, 32'd0, 32'd5, 2);
    run_op("divu 5/0",      3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("div ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // FlushE beats StartE in IDLE
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; MDOpE = 3'd0; SrcAE = 32'd2; SrcBE = 32'd2;
    #1;
    check("flush+start stall", {31'd0, StallMD}, 32'd0);
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    check("flush+start idle stall", {31'd0, StallMD}, 32'd0);

    // Flush at iteration 10 of a DIV
    @(negedge clk);
    StartE = 1'b1; MDOpE = 3'd4; SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    #1;
    check("flush div busy stall", {31'd0, StallMD}, 32'd1);
    @(posedge clk); #1;
    FlushE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    check("flush stall low", {31'd0, StallMD}, 32'd0);
    check("flush no valid",  {31'd0, MDValidE}, 32'd0);
    valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (MDValidE) valids++;
    end
    check("flush no late valid", 32'(valids), 32'd0);
    run_op("mul 3*4",       3'd0, 32'd3, 32'd4, 32'd12, 34);

    // Asynchronous reset mid-MUL
    @(negedge clk);
    StartE = 1'b1; MDOpE = 3'd0; SrcAE = 32'd5; SrcBE = 32'd6;
    repeat (5) @(negedge clk);
    StartE = 1'b0;
    #1;
    check("pre-reset busy stall", {31'd0, StallMD}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset stall",  {31'd0, StallMD},  32'd0);
    check("async reset valid",  {31'd0, MDValidE}, 32'd0);
    check("async reset result", MDResultE, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (MDValidE || StallMD) valids++;
    end
    check("post-reset quiet", 32'(valids), 32'd0);

    // First start straight after reset release
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op("mulhsu -1*2",   3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter word_width, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port FlushE, input, 1 bit: the Execute-stage flush; it aborts any operation in progress.
REQ-005 The block SHALL have port StartE, input, 1 bit: a multiply or divide instruction is present in Execute.
REQ-006 The block SHALL have port MDOpE, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 The block SHALL have ports SrcAE and SrcBE, input, word_width each: the forwarded operands, rs1 and rs2 respectively.
REQ-008 The block SHALL have port StallMD, output, 1 bit: holds the Fetch, Decode and Execute stages while high.
REQ-009 The block SHALL have port MDValidE, output, 1 bit: MDResultE is valid this cycle.
REQ-010 The block SHALL have port MDResultE, output, word_width: the operation result.

Function
REQ-011 The state machine SHALL use the states IDLE, MUL, DIV and DONE.
REQ-012 In IDLE, StartE=1 with FlushE=0 SHALL latch the operands and MDOpE and clear the 6-bit counter at the rising edge.
REQ-013 A start SHALL move to MUL (op 0-3), to DIV (op 4-7), or directly to DONE for a special case (REQ-018, REQ-019).
REQ-014 Operand conditioning SHALL be done at latch time: signed operands are replaced by their magnitudes and the result sign is recorded; MULHSU treats SrcAE as signed and SrcBE as unsigned.
REQ-015 MUL SHALL perform one shift-add step per cycle for exactly 32 cycles into a 64-bit product, then move to DONE.
REQ-016 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then move to DONE.
REQ-017 In DONE, the sign SHALL be applied and MDResultE selected: MUL gives product[31:0], the MULH variants give product[63:32], DIV/DIVU give the quotient, REM/REMU give the remainder; the remainder takes the dividend's sign.
REQ-018 Divide by zero (SrcBE=0) SHALL go directly to DONE with quotient 32'hFFFFFFFF and remainder equal to SrcAE.
REQ-019 Signed overflow (DIV/REM with SrcAE=32'h80000000 and SrcBE=32'hFFFFFFFF) SHALL go directly to DONE with quotient 32'h80000000 and remainder 0.
REQ-020 StallMD SHALL be combinational: 1 when (IDLE and StartE and not FlushE), or when in MUL or DIV; otherwise 0.
REQ-021 In DONE, MDValidE SHALL be 1 and StallMD 0, so the instruction advances at the end of that cycle; DONE SHALL always return to IDLE next cycle.
REQ-022 StartE SHALL be ignored in DONE, since it belongs to the completing instruction.
REQ-023 Latency SHALL be as follows: for a normal operation, StallMD is high for 33 cycles (the start cycle plus 32 iterations), and MDValidE is high in cycle 34 counted from the start cycle as cycle 1; for a special case, MDValidE is high in cycle 2.
REQ-024 FlushE=1 in any state SHALL force IDLE at the next edge, with no MDValidE pulse; FlushE takes priority over StartE.
REQ-025 Outside DONE, MDValidE SHALL be 0 and MDResultE SHALL be 0.
REQ-026 Changes on SrcAE, SrcBE or MDOpE after the start cycle SHALL NOT affect the result.
REQ-027 All arithmetic SHALL be modulo 2^32 on the result; intermediate registers are 64 bits (product) and 33 bits (partial remainder).

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, set the counter, operand, product, quotient and remainder registers to 0, set MDValidE=0 and MDResultE=0, and set StallMD to the value REQ-020 gives in IDLE.
REQ-029 A reset asserted during MUL or DIV SHALL abandon the operation, with no MDValidE pulse after release.
REQ-030 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-031 MUL with SrcAE=7, SrcBE=-3 -> StallMD high for 33 cycles, then MDValidE=1 with MDResultE=32'hFFFFFFEB.
REQ-032 MULHU with SrcAE=SrcBE=32'hFFFFFFFF -> MDResultE=32'hFFFFFFFE; MULH with the same operands -> 0.
REQ-033 DIV with -20 and 3 -> -6 (32'hFFFFFFFA); REM with -20 and 3 -> -2; DIVU with 100 and 7 -> 14; REMU with 100 and 7 -> 2.
REQ-034 DIV with SrcAE=5, SrcBE=0 -> MDValidE in cycle 2 with 32'hFFFFFFFF; REM with the same operands -> 5; DIV with 32'h80000000 and -1 -> 32'h80000000 in cycle 2.
REQ-035 FlushE pulsed at iteration 10 of a DIV -> IDLE next cycle and StallMD=0, no MDValidE pulse; an immediate new MUL with 3 and 4 -> 12.
REQ-036 rst_n low mid-MUL -> all outputs reset asynchronously; after release, MULHSU with 32'hFFFFFFFF and 2 -> 32'hFFFFFFFF.
